// File: rtl/tag_memory_sa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tag_memory_sa_pkg : shared widths, FSM encoding, log2 helper         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tag_memory_sa_pkg;

   localparam int unsigned BW_TAG_DEFAULT = 22;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_e;

   // Ceiling log2, never below 1 so single-entry dimensions still get a bit.
   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tag_memory_sa_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tag_memory_sa_if : request/response bundle of the tag store          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface tag_memory_sa_if #(
   parameter int unsigned BW_SET = 5,
   parameter int unsigned BW_WAY = 2,
   parameter int unsigned BW_TAG = 22
);
   logic              lookup_i;
   logic [BW_SET-1:0] set_i;
   logic [BW_TAG-1:0] tag_i;
   logic              wren_i;
   logic              rmen_i;
   logic [BW_WAY-1:0] way_i;
   logic              dirty_i;
   logic              mark_i;
   logic              flush_i;
   logic              valid_o;
   logic              hit_o;
   logic [BW_WAY-1:0] way_o;
   logic              multi_hit_o;
   logic [BW_WAY-1:0] victim_way_o;
   logic [BW_TAG-1:0] victim_tag_o;
   logic              victim_valid_o;
   logic              victim_dirty_o;
   logic              busy_o;

   modport master (
      output lookup_i, set_i, tag_i, wren_i, rmen_i, way_i, dirty_i, mark_i, flush_i,
      input  valid_o, hit_o, way_o, multi_hit_o, victim_way_o, victim_tag_o,
             victim_valid_o, victim_dirty_o, busy_o
   );

   modport slave (
      input  lookup_i, set_i, tag_i, wren_i, rmen_i, way_i, dirty_i, mark_i, flush_i,
      output valid_o, hit_o, way_o, multi_hit_o, victim_way_o, victim_tag_o,
             victim_valid_o, victim_dirty_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/tag_way_match_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tag_way_match_encoder : one-hot-ish vector -> any, lowest index, >1  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tag_way_match_encoder
   import tag_memory_sa_pkg::*;
#(
   parameter int unsigned ASSOC = 4
) (
   input  wire logic [ASSOC-1:0]                match_i,
   output logic                                 any_o,
   output logic [clog2_min1(ASSOC)-1:0]         way_o,
   output logic                                 multi_o
);
   localparam int unsigned BW_WAY = clog2_min1(ASSOC);

   assign any_o   = |match_i;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_o = |(match_i & (match_i - 1'b1));

   always_comb begin
      way_o = '0;
      for (int i = int'(ASSOC) - 1; i >= 0; i--) begin
         if (match_i[i]) way_o = BW_WAY'(i);
      end
   end
endmodule
`default_nettype wire

// File: rtl/tag_memory_sa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tag_memory_sa : set-associative tag store, registered lookup, flush  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tag_memory_sa
   import tag_memory_sa_pkg::*;
#(
   parameter int unsigned CACHE_BLOCK_CAPACITY = 128,
   parameter int unsigned ASSOC                = 4,
   parameter int unsigned BW_TAG               = BW_TAG_DEFAULT
) (
   input  wire logic       clock_i,
   input  wire logic       reset_i,
   tag_memory_sa_if.slave  bus
);
   localparam int unsigned N_SETS   = CACHE_BLOCK_CAPACITY / ASSOC;
   localparam int unsigned BW_SET   = clog2_min1(N_SETS);
   localparam int unsigned BW_WAY   = clog2_min1(ASSOC);
   localparam logic [BW_SET-1:0] LAST_SET = BW_SET'(N_SETS - 1);

   state_e            state_q, state_d;
   logic [BW_SET-1:0] cnt_q, cnt_d;
   logic              sweep_last;

   logic [ASSOC-1:0]  valid_q [N_SETS];
   logic [ASSOC-1:0]  dirty_q [N_SETS];
   logic [BW_WAY-1:0] rr_q    [N_SETS];

   logic              lookup_q;
   logic [ASSOC-1:0]  rd_valid_q, rd_dirty_q;
   logic [BW_WAY-1:0] rd_rr_q;
   logic [BW_TAG-1:0] cmp_tag_q;

   logic                         idle, lookup_en, wr_en;
   logic [ASSOC-1:0]             match;
   logic [ASSOC-1:0][BW_TAG-1:0] rd_tags;
   logic                         hit, multi, any_invalid, unused_inv_multi;
   logic [BW_WAY-1:0]            hit_way, first_invalid, victim_way;

   assign idle      = (state_q == ST_IDLE);
   assign lookup_en = idle & bus.lookup_i;
   assign wr_en     = idle & bus.wren_i & ~bus.rmen_i;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sweep_last = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.flush_i) state_d = ST_SWEEP;
         end
         ST_SWEEP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SET) begin
               sweep_last = 1'b1;
               cnt_d      = '0;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line state; remove wins over write, write wins over mark.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int s = 0; s < int'(N_SETS); s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else if (state_q == ST_SWEEP) begin
         valid_q[cnt_q] <= '0;
         dirty_q[cnt_q] <= '0;
         if (sweep_last) begin
            for (int s = 0; s < int'(N_SETS); s++) rr_q[s] <= '0;
         end
      end else begin
         if (bus.rmen_i) begin
            valid_q[bus.set_i][bus.way_i] <= 1'b0;
            dirty_q[bus.set_i][bus.way_i] <= 1'b0;
         end else if (bus.wren_i) begin
            valid_q[bus.set_i][bus.way_i] <= 1'b1;
            dirty_q[bus.set_i][bus.way_i] <= bus.dirty_i;
         end else if (bus.mark_i) begin
            dirty_q[bus.set_i][bus.way_i] <= 1'b1;
         end
         if (bus.wren_i && (bus.way_i == rr_q[bus.set_i])) begin
            rr_q[bus.set_i] <= rr_q[bus.set_i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         lookup_q   <= 1'b0;
         rd_valid_q <= '0;
         rd_dirty_q <= '0;
         rd_rr_q    <= '0;
         cmp_tag_q  <= '0;
      end else begin
         lookup_q <= lookup_en;
         if (lookup_en) begin
            rd_valid_q <= valid_q[bus.set_i];
            rd_dirty_q <= dirty_q[bus.set_i];
            rd_rr_q    <= rr_q[bus.set_i];
            cmp_tag_q  <= bus.tag_i;
         end
      end
   end

   // One synchronous-read tag array per way so each maps onto its own RAM.
   for (genvar w = 0; w < int'(ASSOC); w++) begin : g_way
      logic [BW_TAG-1:0] tag_mem [N_SETS];
      logic [BW_TAG-1:0] rd_tag_q;

      always_ff @(posedge clock_i) begin
         if (wr_en && (bus.way_i == BW_WAY'(w))) tag_mem[bus.set_i] <= bus.tag_i;
         if (lookup_en) rd_tag_q <= tag_mem[bus.set_i];
      end

      assign rd_tags[w] = rd_tag_q;
      assign match[w]   = rd_valid_q[w] && (rd_tag_q == cmp_tag_q);
   end

   tag_way_match_encoder #(.ASSOC(ASSOC)) u_hit_enc (
      .match_i (match),
      .any_o   (hit),
      .way_o   (hit_way),
      .multi_o (multi)
   );

   tag_way_match_encoder #(.ASSOC(ASSOC)) u_inv_enc (
      .match_i (~rd_valid_q),
      .any_o   (any_invalid),
      .way_o   (first_invalid),
      .multi_o (unused_inv_multi)
   );

   assign victim_way = any_invalid ? first_invalid : rd_rr_q;

   assign bus.valid_o        = lookup_q;
   assign bus.hit_o          = lookup_q & hit;
   assign bus.way_o          = (lookup_q & hit) ? hit_way : '0;
   assign bus.multi_hit_o    = lookup_q & multi;
   assign bus.victim_way_o   = lookup_q ? victim_way : '0;
   assign bus.victim_tag_o   = lookup_q ? rd_tags[victim_way] : '0;
   assign bus.victim_valid_o = lookup_q & rd_valid_q[victim_way];
   assign bus.victim_dirty_o = lookup_q & rd_dirty_q[victim_way];
   assign bus.busy_o         = (state_q == ST_SWEEP);
endmodule
`default_nettype wire

// File: tb/tb_tag_memory_sa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tag_memory_sa : directed self-checking bench, 128 lines / 4 ways  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_tag_memory_sa;
   localparam int BW_SET = 5;
   localparam int BW_WAY = 2;
   localparam int BW_TAG = 22;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc;

   always #5 clk = ~clk;

   tag_memory_sa_if #(.BW_SET(BW_SET), .BW_WAY(BW_WAY), .BW_TAG(BW_TAG)) bus ();

   tag_memory_sa #(.CACHE_BLOCK_CAPACITY(128), .ASSOC(4), .BW_TAG(BW_TAG)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic clear_ops();
      bus.lookup_i = 1'b0;
      bus.wren_i   = 1'b0;
      bus.rmen_i   = 1'b0;
      bus.mark_i   = 1'b0;
      bus.flush_i  = 1'b0;
      bus.dirty_i  = 1'b0;
      bus.set_i    = '0;
      bus.way_i    = '0;
      bus.tag_i    = '0;
   endtask

   task automatic do_write(input logic [4:0] s, input logic [1:0] w, input logic [21:0] t,
                           input logic d);
      bus.set_i = s; bus.way_i = w; bus.tag_i = t; bus.dirty_i = d;
      bus.wren_i = 1'b1;
      tick();
      bus.wren_i = 1'b0; bus.dirty_i = 1'b0;
   endtask

   task automatic do_lookup(input logic [4:0] s, input logic [21:0] t);
      bus.set_i = s; bus.tag_i = t;
      bus.lookup_i = 1'b1;
      tick();
      bus.lookup_i = 1'b0;
   endtask

   task automatic do_op(input logic [4:0] s, input logic [1:0] w, input logic [21:0] t,
                        input logic wr, input logic rm, input logic mk);
      bus.set_i = s; bus.way_i = w; bus.tag_i = t;
      bus.wren_i = wr; bus.rmen_i = rm; bus.mark_i = mk;
      tick();
      bus.wren_i = 1'b0; bus.rmen_i = 1'b0; bus.mark_i = 1'b0;
   endtask

   initial begin
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      clear_ops();
      rst = 1'b1;
      tick(); tick();
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_hit", bus.hit_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_vvalid", bus.victim_valid_o, 0);
      rst = 1'b0;
      tick();

      do_lookup(5'd3, 22'h1234);
      chk("empty_valid", bus.valid_o, 1);
      chk("empty_hit", bus.hit_o, 0);
      chk("empty_vway", bus.victim_way_o, 0);
      chk("empty_vvalid", bus.victim_valid_o, 0);
      tick();
      chk("pulse_clear", bus.valid_o, 0);

      for (int w = 0; w < 4; w++) do_write(5'd5, 2'(w), 22'hA0 + 22'(w), 1'b0);
      do_lookup(5'd5, 22'hA2);
      chk("hitA2_hit", bus.hit_o, 1);
      chk("hitA2_way", bus.way_o, 2);
      chk("hitA2_multi", bus.multi_hit_o, 0);
      do_lookup(5'd5, 22'hA4);
      chk("missA4_hit", bus.hit_o, 0);
      chk("missA4_way", bus.way_o, 0);
      chk("missA4_vway", bus.victim_way_o, 0);
      chk("missA4_vtag", bus.victim_tag_o, 32'hA0);
      chk("missA4_vvalid", bus.victim_valid_o, 1);

      // Set 6 ends with its round-robin pointer at 1.
      for (int w = 0; w < 4; w++) do_write(5'd6, 2'(w), 22'h60 + 22'(w), 1'b0);
      do_write(5'd6, 2'd0, 22'h64, 1'b0);

      for (int i = 0; i < 5; i++) begin
         do_lookup(5'd5, 22'hA4);
         chk($sformatf("rr_seq%0d", i), bus.victim_way_o, 32'(exp_seq[i]));
         if (i < 4) do_write(5'd5, exp_seq[i], 22'hB0 + 22'(i), 1'b0);
      end
      do_lookup(5'd6, 22'h77);
      chk("rr_other_set", bus.victim_way_o, 1);

      do_write(5'd7, 2'd1, 22'hC1, 1'b1);
      do_write(5'd7, 2'd0, 22'hC0, 1'b0);
      do_write(5'd7, 2'd2, 22'hC2, 1'b0);
      do_write(5'd7, 2'd3, 22'hC3, 1'b0);
      do_lookup(5'd7, 22'hDD);
      chk("dirty_vway", bus.victim_way_o, 1);
      chk("dirty_vtag", bus.victim_tag_o, 32'hC1);
      chk("dirty_vdirty", bus.victim_dirty_o, 1);

      do_op(5'd7, 2'd1, 22'h0, 1'b0, 1'b1, 1'b0);
      do_lookup(5'd7, 22'hC1);
      chk("rm_hit", bus.hit_o, 0);
      chk("rm_vway", bus.victim_way_o, 1);
      chk("rm_vvalid", bus.victim_valid_o, 0);
      chk("rm_vdirty", bus.victim_dirty_o, 0);

      do_op(5'd7, 2'd1, 22'hC5, 1'b1, 1'b0, 1'b1);
      do_lookup(5'd7, 22'hC5);
      chk("wrmk_hit", bus.hit_o, 1);
      chk("wrmk_way", bus.way_o, 1);
      chk("wrmk_vway", bus.victim_way_o, 2);
      chk("wrmk_vdirty", bus.victim_dirty_o, 0);

      do_op(5'd7, 2'd2, 22'h0, 1'b0, 1'b0, 1'b1);
      do_lookup(5'd7, 22'hDD);
      chk("mark_vway", bus.victim_way_o, 2);
      chk("mark_vdirty", bus.victim_dirty_o, 1);

      do_op(5'd7, 2'd3, 22'hF3, 1'b1, 1'b1, 1'b0);
      do_lookup(5'd7, 22'hF3);
      chk("rmwr_hit", bus.hit_o, 0);
      chk("rmwr_vway", bus.victim_way_o, 3);
      chk("rmwr_vvalid", bus.victim_valid_o, 0);

      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      bus.set_i = 5'd5; bus.tag_i = 22'hB0; bus.lookup_i = 1'b1;
      cyc = 0;
      while (bus.busy_o === 1'b1 && cyc < 100) begin
         chk("sweep_valid", bus.valid_o, 0);
         tick();
         cyc++;
      end
      bus.lookup_i = 1'b0;
      chk("sweep_len", cyc, 32);
      chk("post_sweep_valid", bus.valid_o, 0);

      do_lookup(5'd5, 22'hB0);
      chk("flushed5_hit", bus.hit_o, 0);
      chk("flushed5_vvalid", bus.victim_valid_o, 0);
      do_lookup(5'd7, 22'hC5);
      chk("flushed7_hit", bus.hit_o, 0);
      do_lookup(5'd31, 22'h0);
      chk("flushed31_vvalid", bus.victim_valid_o, 0);

      do_write(5'd6, 2'd1, 22'h71, 1'b0);
      do_write(5'd6, 2'd2, 22'h72, 1'b0);
      do_write(5'd6, 2'd3, 22'h73, 1'b0);
      do_write(5'd6, 2'd0, 22'h70, 1'b0);
      do_lookup(5'd6, 22'h77);
      chk("rr_after_flush", bus.victim_way_o, 1);

      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      repeat (10) tick();
      chk("midsweep_busy", bus.busy_o, 1);
      rst = 1'b1;
      bus.lookup_i = 1'b1;
      tick();
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_valid", bus.valid_o, 0);
      chk("abort_hit", bus.hit_o, 0);
      chk("abort_vway", bus.victim_way_o, 0);
      chk("abort_vtag", bus.victim_tag_o, 0);
      rst = 1'b0;
      bus.lookup_i = 1'b0;
      tick();
      chk("idle_after_abort", bus.busy_o, 0);

      do_write(5'd9, 2'd1, 22'h55, 1'b0);
      do_write(5'd9, 2'd3, 22'h55, 1'b0);
      do_lookup(5'd9, 22'h55);
      chk("dup_hit", bus.hit_o, 1);
      chk("dup_way", bus.way_o, 1);
      chk("dup_multi", bus.multi_hit_o, 1);
      chk("dup_vway", bus.victim_way_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
